merge_d3: RTL

- Clocked 3-to-1 dual-rail merge. It is the collecting end of the 3-way steer path.
- It receives the one-hot steer token (`steerin`) and the three steered dual-rail channels S/T/U.
- It forwards the selected channel's wavefront to the single output Z.
- It returns four-phase completion (COMP) to the selected channel and to the steer token source.
- COMP semantics: 0 = requesting DATA, 1 = requesting NULL.

---
 rtl/merge_d3.sv | 134 +++++++++++++
 1 files changed

// File: rtl/merge_d3.sv
// Clocked 3-to-1 dual-rail merge: collects the wavefront of the channel chosen by
// a one-hot steer token, forwards it to Z and returns four-phase completion.
module merge_d3 #(
    parameter int N = 1
) (
    input  logic           clk,
    input  logic           init,
    input  logic [2*N-1:0] Ss,
    output logic           SCOMP,
    input  logic [2*N-1:0] Ts,
    output logic           TCOMP,
    input  logic [2*N-1:0] Us,
    output logic           UCOMP,
    input  logic [2:0]     steerin,
    output logic           steerinCOMP,
    output logic [2*N-1:0] Z,
    input  logic           ZCOMP,
    output logic           err
);
    localparam int W = 2 * N;

    typedef enum logic [1:0] {IDLE, HOLD, ACK, DRAIN} state_t;

    state_t         state_reg, state_next;
    logic [1:0]     sel_reg, sel_next;
    logic [W-1:0]   z_reg, z_next;
    logic [2:0]     comp_reg, comp_next;
    logic           err_reg, err_next;

    logic [W-1:0]   chan [3];
    logic [2:0]     full, nul, bad;

    function automatic logic is_full(input logic [W-1:0] b);
        is_full = 1'b1;
        for (int i = 0; i < N; i++)
            if (b[2*i] == b[2*i+1]) is_full = 1'b0;
    endfunction

    function automatic logic is_bad(input logic [W-1:0] b);
        is_bad = 1'b0;
        for (int i = 0; i < N; i++)
            if (b[2*i] && b[2*i+1]) is_bad = 1'b1;
    endfunction

    assign chan[0] = Ss;
    assign chan[1] = Ts;
    assign chan[2] = Us;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_class
            assign full[gi] = is_full(chan[gi]);
            assign nul[gi]  = (chan[gi] == '0);
            assign bad[gi]  = is_bad(chan[gi]);
        end
    endgenerate

    logic       onehot, multi;
    logic [1:0] idx;
    logic [2:0] sel_mask;

    assign onehot   = (steerin == 3'b001) || (steerin == 3'b010) || (steerin == 3'b100);
    assign multi    = ($countones(steerin) > 1);
    assign sel_mask = 3'b001 << sel_reg;

    always_comb begin
        case (steerin)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        z_next     = z_reg;
        comp_next  = comp_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (multi || (onehot && |(steerin & bad))) err_next = 1'b1;
                if (onehot && |(steerin & full) && !ZCOMP) begin
                    z_next     = chan[idx];
                    sel_next   = idx;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (|(sel_mask & bad) || (onehot && steerin != sel_mask)) err_next = 1'b1;
                if (ZCOMP) begin
                    comp_next  = sel_mask;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (|(sel_mask & bad) || (onehot && steerin != sel_mask)) err_next = 1'b1;
                // Both the channel and the token must be back at NULL before Z is cleared.
                if (|(sel_mask & nul) && steerin == 3'b000) begin
                    z_next     = '0;
                    state_next = DRAIN;
                end
            end
            default: begin
                if (!ZCOMP) begin
                    comp_next  = 3'b000;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
            z_reg     <= '0;
            comp_reg  <= 3'b000;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            z_reg     <= z_next;
            comp_reg  <= comp_next;
            err_reg   <= err_next;
        end
    end

    assign SCOMP       = comp_reg[0];
    assign TCOMP       = comp_reg[1];
    assign UCOMP       = comp_reg[2];
    assign steerinCOMP = |comp_reg;
    assign Z           = z_reg;
    assign err         = err_reg;
endmodule
